// File: rtl/plot_arbiter.sv
// Round-robin arbiter that serves three rectangle-fill requesters and streams their pixels to a VGA adapter.
// Optional build macro PLOT_ARBITER_CLIP_EN suppresses plot for pixels beyond 159 x 119.
module plot_arbiter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  req,
   input  logic [23:0] req_x,
   input  logic [20:0] req_y,
   input  logic [8:0]  req_colour,
   input  logic [11:0] req_w,
   input  logic [11:0] req_h,
   output logic [2:0]  grant,
   output logic [2:0]  done,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        busy
);

   localparam int unsigned XW    = 8;
   localparam int unsigned YW    = 7;
   localparam int unsigned CW    = 3;
   localparam int unsigned DW    = 4;
   localparam int unsigned XSUMW = XW + 1;
   localparam int unsigned YSUMW = YW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [1:0]      win_q, win_d;
   logic [XW-1:0]   x0_q, x0_d;
   logic [YW-1:0]   y0_q, y0_d;
   logic [CW-1:0]   col_q, col_d;
   logic [DW-1:0]   w_q, w_d, h_q, h_d;
   logic [DW-1:0]   dx_q, dx_d, dy_q, dy_d;
   logic [2:0]      grant_q, grant_d, done_q, done_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [CW-1:0]   colour_q, colour_d;
   logic            plot_q, plot_d, busy_q, busy_d;

   logic [1:0]      pick_c;
   logic [XW-1:0]   sel_x_c;
   logic [YW-1:0]   sel_y_c;
   logic [CW-1:0]   sel_col_c;
   logic [DW-1:0]   sel_w_c, sel_h_c;
   logic [XW-1:0]   base_x_c;
   logic [YW-1:0]   base_y_c;
   logic [DW-1:0]   pix_dx_c, pix_dy_c;
   logic [XSUMW-1:0] xs_c;
   logic [YSUMW-1:0] ys_c;
   logic            last_c;

   // Round-robin pick: first asserted request at or after the pointer.
   always_comb begin
      pick_c = 2'd0;
      case (ptr_q)
         2'd0:    pick_c = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
         2'd1:    pick_c = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         default: pick_c = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      endcase
   end

   // Field mux for the requester granted in the previous cycle.
   always_comb begin
      sel_x_c   = req_x[7:0];
      sel_y_c   = req_y[6:0];
      sel_col_c = req_colour[2:0];
      sel_w_c   = req_w[3:0];
      sel_h_c   = req_h[3:0];
      case (win_q)
         2'd1: begin
            sel_x_c   = req_x[15:8];
            sel_y_c   = req_y[13:7];
            sel_col_c = req_colour[5:3];
            sel_w_c   = req_w[7:4];
            sel_h_c   = req_h[7:4];
         end
         2'd2: begin
            sel_x_c   = req_x[23:16];
            sel_y_c   = req_y[20:14];
            sel_col_c = req_colour[8:6];
            sel_w_c   = req_w[11:8];
            sel_h_c   = req_h[11:8];
         end
         default: ;
      endcase
   end

   assign last_c = (dx_q == w_q) && (dy_q == h_q);

   // Coordinates of the pixel presented in the next cycle.
   always_comb begin
      base_x_c = x0_q;
      base_y_c = y0_q;
      pix_dx_c = DW'(dx_q + 4'd1);
      pix_dy_c = dy_q;
      if (state_q == S_LOAD) begin
         base_x_c = sel_x_c;
         base_y_c = sel_y_c;
         pix_dx_c = '0;
         pix_dy_c = '0;
      end else if (dx_q == w_q) begin
         pix_dx_c = '0;
         pix_dy_c = DW'(dy_q + 4'd1);
      end
   end

   assign xs_c = XSUMW'(base_x_c) + XSUMW'(pix_dx_c);
   assign ys_c = YSUMW'(base_y_c) + YSUMW'(pix_dy_c);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         win_q    <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         col_q    <= '0;
         w_q      <= '0;
         h_q      <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         col_q    <= col_d;
         w_q      <= w_d;
         h_q      <= h_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      col_d    = col_q;
      w_d      = w_q;
      h_d      = h_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      grant_d  = '0;
      done_d   = '0;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_LOAD;
               win_d   = pick_c;
               grant_d = 3'b001 << pick_c;
            end
         end
         S_LOAD: begin
            state_d = S_DRAW;
            x0_d    = sel_x_c;
            y0_d    = sel_y_c;
            col_d   = sel_col_c;
            w_d     = sel_w_c;
            h_d     = sel_h_c;
            dx_d    = '0;
            dy_d    = '0;
         end
         S_DRAW: begin
            if (last_c) begin
               state_d = S_DONE;
               done_d  = 3'b001 << win_q;
            end else begin
               dx_d = pix_dx_c;
               dy_d = pix_dy_c;
            end
         end
         default: begin
            state_d = S_IDLE;
            ptr_d   = (win_q == 2'd2) ? 2'd0 : 2'(win_q + 2'd1);
         end
      endcase

      // Present a pixel in every DRAW cycle, including the one loaded at the end of LOAD.
      if (state_q == S_LOAD || (state_q == S_DRAW && !last_c)) begin
         x_d      = xs_c[XW-1:0];
         y_d      = ys_c[YW-1:0];
         colour_d = (state_q == S_LOAD) ? sel_col_c : col_q;
`ifdef PLOT_ARBITER_CLIP_EN
         plot_d   = (xs_c <= XSUMW'(159)) && (ys_c <= YSUMW'(119));
`else
         plot_d   = 1'b1;
`endif
      end

      busy_d = (state_d != S_IDLE);
   end

`ifndef PLOT_ARBITER_CLIP_EN
   // Carry bits only matter for clipping; without it coordinates wrap.
   logic unused_carry_c;
   assign unused_carry_c = xs_c[XSUMW-1] ^ ys_c[YSUMW-1];
`endif

   assign grant  = grant_q;
   assign done   = done_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter; honours PLOT_ARBITER_CLIP_EN when defined.
module tb_plot_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  req;
   logic [23:0] req_x;
   logic [20:0] req_y;
   logic [8:0]  req_colour;
   logic [11:0] req_w;
   logic [11:0] req_h;
   logic [2:0]  grant, done;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot, busy;

   int n_checks = 0;
   int n_pass   = 0;

   plot_arbiter dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .req_w      (req_w),
      .req_h      (req_h),
      .grant      (grant),
      .done       (done),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input int idx, input int fx, input int fy, input int fc,
                             input int fw, input int fh);
      req_x[8*idx +: 8]      = 8'(fx);
      req_y[7*idx +: 7]      = 7'(fy);
      req_colour[3*idx +: 3] = 3'(fc);
      req_w[4*idx +: 4]      = 4'(fw);
      req_h[4*idx +: 4]      = 4'(fh);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req     = '0;
      tick();
      tick();
      n_checks++;
      if ({grant, done, plot, busy} !== 8'b0)
         $display("FAIL reset_ctrl: grant=%b done=%b plot=%b busy=%b expected all 0", grant, done, plot, busy);
      else n_pass++;
      n_checks++;
      if ({x, y, colour} !== 18'b0)
         $display("FAIL reset_pixel: x=%0d y=%0d colour=%0d expected 0/0/0", x, y, colour);
      else n_pass++;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      set_fields(0, 10, 20, 5, 1, 1);
      req = 3'b001;
      tick();
      req = 3'b000;
      n_checks++;
      if (grant !== 3'b001 || busy !== 1'b1 || plot !== 1'b0)
         $display("FAIL single_grant: grant=%b busy=%b plot=%b expected 001/1/0", grant, busy, plot);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (plot !== 1'b1 || x !== 8'(10 + k % 2) || y !== 7'(20 + k / 2) || colour !== 3'd5 || grant !== 3'b000)
            $display("FAIL single_pixel%0d: plot=%b x=%0d y=%0d c=%0d expected 1 %0d %0d 5",
                     k, plot, x, y, colour, 10 + k % 2, 20 + k / 2);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (done !== 3'b001 || plot !== 1'b0 || busy !== 1'b1 || x !== 8'd11 || y !== 7'd21)
         $display("FAIL single_done: done=%b plot=%b busy=%b x=%0d y=%0d expected 001 0 1 11 21",
                  done, plot, busy, x, y);
      else n_pass++;
      tick();
      n_checks++;
      if (done !== 3'b000 || busy !== 1'b0)
         $display("FAIL single_idle: done=%b busy=%b expected 000 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_contention();
      logic [2:0] exp_g;
      int         order [4] = '{0, 1, 2, 0};
      do_reset();
      for (int i = 0; i < 3; i++) set_fields(i, 30 + i, 40 + i, i + 1, 0, 0);
      req = 3'b111;
      for (int r = 0; r < 4; r++) begin
         exp_g = 3'b001 << order[r];
         tick();
         n_checks++;
         if (grant !== exp_g)
            $display("FAIL contention_grant%0d: grant=%b expected %b", r, grant, exp_g);
         else n_pass++;
         tick();
         n_checks++;
         if (plot !== 1'b1 || x !== 8'(30 + order[r]) || y !== 7'(40 + order[r]) || grant !== 3'b000)
            $display("FAIL contention_pixel%0d: plot=%b x=%0d y=%0d grant=%b expected 1 %0d %0d 000",
                     r, plot, x, y, grant, 30 + order[r], 40 + order[r]);
         else n_pass++;
         tick();
         n_checks++;
         if (done !== exp_g || grant !== 3'b000)
            $display("FAIL contention_done%0d: done=%b grant=%b expected %b 000", r, done, grant, exp_g);
         else n_pass++;
         if (r == 3) req = 3'b000;
         tick();
         n_checks++;
         if (busy !== 1'b0 || grant !== 3'b000 || done !== 3'b000)
            $display("FAIL contention_idle%0d: busy=%b grant=%b done=%b expected 0 000 000", r, busy, grant, done);
         else n_pass++;
      end
   endtask

   task automatic test_one_pixel();
      do_reset();
      set_fields(2, 5, 6, 7, 0, 0);
      req = 3'b100;
      tick();
      req = 3'b000;
      n_checks++;
      if (grant !== 3'b100)
         $display("FAIL onepix_grant: grant=%b expected 100", grant);
      else n_pass++;
      tick();
      n_checks++;
      if (plot !== 1'b1 || x !== 8'd5 || y !== 7'd6 || colour !== 3'd7)
         $display("FAIL onepix_pixel: plot=%b x=%0d y=%0d c=%0d expected 1 5 6 7", plot, x, y, colour);
      else n_pass++;
      tick();
      n_checks++;
      if (done !== 3'b100 || plot !== 1'b0)
         $display("FAIL onepix_done: done=%b plot=%b expected 100 0", done, plot);
      else n_pass++;
      tick();
   endtask

   task automatic test_clip();
      logic exp_plot;
      do_reset();
      set_fields(0, 158, 119, 3, 3, 0);
      req = 3'b001;
      tick();
      req = 3'b000;
      for (int k = 0; k < 4; k++) begin
         tick();
`ifdef PLOT_ARBITER_CLIP_EN
         exp_plot = (k < 2);
`else
         exp_plot = 1'b1;
`endif
         n_checks++;
         if (plot !== exp_plot || x !== 8'(158 + k) || y !== 7'd119 || busy !== 1'b1)
            $display("FAIL clip_pixel%0d: plot=%b x=%0d y=%0d expected %b %0d 119",
                     k, plot, x, y, exp_plot, 158 + k);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (done !== 3'b001 || plot !== 1'b0)
         $display("FAIL clip_done: done=%b plot=%b expected 001 0", done, plot);
      else n_pass++;
      tick();
   endtask

   task automatic test_wrap_y();
      logic exp_plot;
      int   ey;
      do_reset();
      set_fields(1, 20, 126, 2, 0, 3);
      req = 3'b010;
      tick();
      req = 3'b000;
      for (int k = 0; k < 4; k++) begin
         tick();
         ey = (126 + k) % 128;
`ifdef PLOT_ARBITER_CLIP_EN
         exp_plot = 1'b0;
`else
         exp_plot = 1'b1;
`endif
         n_checks++;
         if (plot !== exp_plot || x !== 8'd20 || y !== 7'(ey))
            $display("FAIL wrap_pixel%0d: plot=%b x=%0d y=%0d expected %b 20 %0d", k, plot, x, y, exp_plot, ey);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (done !== 3'b010)
         $display("FAIL wrap_done: done=%b expected 010", done);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      int pulses;
      do_reset();
      // Serve requester 0 so the pointer moves to 1 before the interrupted draw.
      set_fields(0, 1, 1, 1, 0, 0);
      req = 3'b001;
      tick();
      req = 3'b000;
      tick();
      tick();
      tick();
      set_fields(1, 60, 50, 6, 3, 3);
      req = 3'b010;
      tick();
      req = 3'b000;
      n_checks++;
      if (grant !== 3'b010)
         $display("FAIL rstmid_grant: grant=%b expected 010", grant);
      else n_pass++;
      tick();
      tick();
      tick();
      n_checks++;
      if (plot !== 1'b1 || x !== 8'd62 || y !== 7'd50)
         $display("FAIL rstmid_pixel3: plot=%b x=%0d y=%0d expected 1 62 50", plot, x, y);
      else n_pass++;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_checks++;
      if (busy !== 1'b0 || plot !== 1'b0 || done !== 3'b000 || x !== 8'd0)
         $display("FAIL rstmid_after: busy=%b plot=%b done=%b x=%0d expected 0 0 000 0", busy, plot, done, x);
      else n_pass++;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done !== 3'b000 || plot !== 1'b0) pulses++;
      end
      n_checks++;
      if (pulses != 0)
         $display("FAIL rstmid_quiet: active cycles=%0d expected 0", pulses);
      else n_pass++;
      req = 3'b111;
      tick();
      req = 3'b000;
      n_checks++;
      if (grant !== 3'b001)
         $display("FAIL rstmid_pointer: grant=%b expected 001", grant);
      else n_pass++;
      tick();
      tick();
      tick();
   endtask

   task automatic test_field_stability();
      do_reset();
      set_fields(1, 50, 60, 5, 1, 0);
      req = 3'b010;
      tick();
      n_checks++;
      if (grant !== 3'b010)
         $display("FAIL stable_grant: grant=%b expected 010", grant);
      else n_pass++;
      tick();
      n_checks++;
      if (plot !== 1'b1 || x !== 8'd50 || y !== 7'd60 || colour !== 3'd5)
         $display("FAIL stable_pixel0: plot=%b x=%0d y=%0d c=%0d expected 1 50 60 5", plot, x, y, colour);
      else n_pass++;
      set_fields(1, 200, 10, 1, 7, 7);
      req = 3'b000;
      tick();
      n_checks++;
      if (plot !== 1'b1 || x !== 8'd51 || y !== 7'd60 || colour !== 3'd5)
         $display("FAIL stable_pixel1: plot=%b x=%0d y=%0d c=%0d expected 1 51 60 5", plot, x, y, colour);
      else n_pass++;
      tick();
      n_checks++;
      if (done !== 3'b010 || plot !== 1'b0)
         $display("FAIL stable_done: done=%b plot=%b expected 010 0", done, plot);
      else n_pass++;
      tick();
      n_checks++;
      if (busy !== 1'b0 || grant !== 3'b000)
         $display("FAIL stable_idle: busy=%b grant=%b expected 0 000", busy, grant);
      else n_pass++;
   endtask

   initial begin
      reset_n    = 1'b0;
      req        = '0;
      req_x      = '0;
      req_y      = '0;
      req_colour = '0;
      req_w      = '0;
      req_h      = '0;
      test_reset();
      test_single();
      test_contention();
      test_one_pixel();
      test_clip();
      test_wrap_y();
      test_reset_mid();
      test_field_stability();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
